// File: rtl/uart_rx_param.sv
// Parametrised asynchronous serial receiver: configurable width, parity, stop bits and oversampling,
// with 2-of-3 mid-bit voting, start-glitch rejection and break-safe framing-error recovery.
module uart_rx_param #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 rxEn,
  input  logic                 rx,
  output logic                 rxBusy,
  output logic                 rxDone,
  output logic                 rxErr,
  output logic                 parityErr,
  output logic [DATA_BITS-1:0] out
);

  localparam int SAMPLE_RATE = BAUD_RATE * OVERSAMPLE;
  localparam int DIV_RAW     = (CLOCK_RATE + SAMPLE_RATE / 2) / SAMPLE_RATE;
  localparam int DIV         = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W      = $clog2(OVERSAMPLE);
  localparam int BIT_CLKS    = DIV * OVERSAMPLE;
  localparam int HIGH_W      = $clog2(BIT_CLKS + 1);
  localparam int MID         = OVERSAMPLE / 2;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, DONE, FRAMEERR, ERRWAIT
  } rxStateT;

  rxStateT state, nextState;

  logic                 rxSync1, rxSync, rxPrev;
  logic [DIV_W-1:0]     divCnt;
  logic [TICK_W-1:0]    tickCnt;
  logic                 sampleA, sampleB;
  logic [3:0]           bitCnt;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 parityFlag;
  logic [HIGH_W-1:0]    highCnt;
  logic                 tick, voteStrobe, voteBit, startEdge, lineIdle, inFrame;

  assign inFrame    = (state == START) || (state == DATA) || (state == PAR) || (state == STOP);
  assign startEdge  = rxPrev & ~rxSync;
  assign tick       = (divCnt == DIV_W'(DIV - 1));
  assign voteStrobe = tick && (tickCnt == TICK_W'(MID));
  assign voteBit    = (sampleA & sampleB) | (sampleA & rxSync) | (sampleB & rxSync);
  assign lineIdle   = rxSync && (highCnt >= HIGH_W'(BIT_CLKS - 1));

  // rxPrev is frozen during DONE so a start edge arriving in that cycle is still seen from IDLE.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rxSync1 <= 1'b1;
      rxSync  <= 1'b1;
      rxPrev  <= 1'b1;
    end else begin
      rxSync1 <= rx;
      rxSync  <= rxSync1;
      if (state != DONE) rxPrev <= rxSync;
    end
  end

  // Bit timing restarts from zero whenever a frame is not in progress.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      divCnt  <= '0;
      tickCnt <= '0;
      sampleA <= 1'b0;
      sampleB <= 1'b0;
    end else if (!inFrame) begin
      divCnt  <= '0;
      tickCnt <= '0;
    end else if (tick) begin
      divCnt  <= '0;
      tickCnt <= (tickCnt == TICK_W'(OVERSAMPLE - 1)) ? '0 : tickCnt + TICK_W'(1);
      if (tickCnt == TICK_W'(MID - 2)) sampleA <= rxSync;
      if (tickCnt == TICK_W'(MID - 1)) sampleB <= rxSync;
    end else begin
      divCnt <= divCnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bitCnt     <= '0;
      shiftReg   <= '0;
      parityFlag <= 1'b0;
      highCnt    <= '0;
      out        <= '0;
    end else begin
      if (state != nextState)  bitCnt <= '0;
      else if (voteStrobe)     bitCnt <= bitCnt + 4'd1;

      if (state == DATA && voteStrobe) shiftReg <= {voteBit, shiftReg[DATA_BITS-1:1]};
      if (state == PAR && voteStrobe)  parityFlag <= (^shiftReg) ^ voteBit ^ (PARITY == 1);

      if (!rxSync || state == FRAMEERR)        highCnt <= '0;
      else if (highCnt != HIGH_W'(BIT_CLKS))   highCnt <= highCnt + HIGH_W'(1);

      if (state == STOP && nextState == DONE)  out <= shiftReg;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves nextState unassigned and infers a latch.
    nextState = state;
    if (!rxEn) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:     if (startEdge) nextState = START;
        START:    if (voteStrobe) nextState = voteBit ? IDLE : DATA;
        DATA:     if (voteStrobe && bitCnt == 4'(DATA_BITS - 1))
                    nextState = (PARITY != 0) ? PAR : STOP;
        PAR:      if (voteStrobe) nextState = STOP;
        STOP:     if (voteStrobe) begin
                    if (!voteBit)                           nextState = FRAMEERR;
                    else if (bitCnt == 4'(STOP_BITS - 1))   nextState = DONE;
                  end
        DONE:     nextState = IDLE;
        FRAMEERR: nextState = ERRWAIT;
        ERRWAIT:  if (lineIdle) nextState = IDLE;
        default:  nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    rxBusy    = inFrame;
    rxDone    = (state == DONE);
    rxErr     = (state == FRAMEERR);
    parityErr = (PARITY != 0) && (state == DONE) && parityFlag;
  end

endmodule
